// File: rtl/noc_arb_pkg.sv
// Shared definitions for the NoC output-port arbiter: port indices, FSM states and
// one-hot/index helpers.
package noc_arb_pkg;

    localparam int unsigned N_PORTS = 5;

    localparam logic [2:0] PORT_N = 3'd0;
    localparam logic [2:0] PORT_E = 3'd1;
    localparam logic [2:0] PORT_W = 3'd2;
    localparam logic [2:0] PORT_S = 3'd3;
    localparam logic [2:0] PORT_L = 3'd4;

    typedef enum logic {
        IDLE,
        SEND
    } arb_state_t;

    function automatic logic [N_PORTS-1:0] idx_to_onehot(input logic [2:0] idx);
        logic [N_PORTS-1:0] oh;
        oh = '0;
        if (int'(idx) < N_PORTS) begin
            oh[idx] = 1'b1;
        end
        return oh;
    endfunction

    function automatic logic [2:0] onehot_to_idx(input logic [N_PORTS-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (oh[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // Successor in round-robin order; L wraps back to N.
    function automatic logic [2:0] next_idx(input logic [2:0] idx);
        return (idx >= PORT_L) ? PORT_N : idx + 3'd1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first requesting port at or after ptr, modulo N_PORTS.
module rr_picker
    import noc_arb_pkg::*;
(
    input  logic [N_PORTS-1:0] req,
    input  logic [2:0]         ptr,
    output logic               valid,
    output logic [2:0]         idx
);

    always_comb begin
        logic [2:0] cand;
        valid = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int k = 0; k < N_PORTS; k++) begin
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
            cand = next_idx(cand);
        end
    end

endmodule

// File: rtl/rr_packet_arbiter.sv
// Output-port allocator: round-robin wormhole arbitration with RTS/DCTS handshake and a
// stall timeout that releases a lock whose owner stops requesting.
module rr_packet_arbiter
    import noc_arb_pkg::*;
#(
    parameter int unsigned STALL_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_PORTS-1:0] req,
    input  logic [N_PORTS-1:0] tail,
    input  logic               DCTS,
    output logic [N_PORTS-1:0] grant,
    output logic [N_PORTS-1:0] Xbar_sel,
    output logic               RTS,
    output logic               busy,
    output logic               err_timeout,
    output logic [2:0]         rr_ptr
);

    localparam int unsigned    CNT_W     = $clog2(STALL_TIMEOUT);
    localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(STALL_TIMEOUT - 1);

    arb_state_t         state_q, state_d;
    logic [2:0]         winner_q, winner_d;
    logic [N_PORTS-1:0] xbar_q, xbar_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic               err_q, err_d;

    logic               pick_valid;
    logic [2:0]         pick_idx;
    logic               xfer;

    rr_picker u_picker (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        xbar_d   = xbar_q;
        ptr_d    = ptr_q;
        stall_d  = stall_q;
        err_d    = 1'b0;
        RTS      = 1'b0;
        xfer     = 1'b0;
        grant    = '0;

        unique case (state_q)
            IDLE: begin
                xbar_d = '0;
                if (pick_valid) begin
                    state_d  = SEND;
                    winner_d = pick_idx;
                    xbar_d   = idx_to_onehot(pick_idx);
                end
            end
            SEND: begin
                RTS  = req[winner_q];
                xfer = RTS & DCTS;
                // xbar_q is the one-hot of the locked winner for the whole packet.
                if (xfer) begin
                    grant = xbar_q;
                end
                if (xfer && tail[winner_q]) begin
                    state_d = IDLE;
                    xbar_d  = '0;
                    ptr_d   = next_idx(winner_q);
                    stall_d = '0;
                end else if (RTS) begin
                    stall_d = '0;
                end else if (stall_q == STALL_MAX) begin
                    state_d = IDLE;
                    xbar_d  = '0;
                    ptr_d   = next_idx(winner_q);
                    stall_d = '0;
                    err_d   = 1'b1;
                end else begin
                    stall_d = stall_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                xbar_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            winner_q <= '0;
            xbar_q   <= '0;
            ptr_q    <= '0;
            stall_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            xbar_q   <= xbar_d;
            ptr_q    <= ptr_d;
            stall_q  <= stall_d;
            err_q    <= err_d;
        end
    end

    assign Xbar_sel    = xbar_q;
    assign busy        = (state_q == SEND);
    assign err_timeout = err_q;
    assign rr_ptr      = ptr_q;

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Scoreboard bench for rr_packet_arbiter: a packet-level reference model queues the expected
// per-cycle outputs and grant events; a monitor on the falling edge pops and compares.
module tb_rr_packet_arbiter;
    import noc_arb_pkg::*;

    localparam int unsigned T = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] req = '0;
    logic [4:0] tail = '0;
    logic       dcts = 1'b0;
    logic [4:0] grant;
    logic [4:0] xbar_sel;
    logic       rts;
    logic       busy;
    logic       err_timeout;
    logic [2:0] rr_ptr;

    always #5 clk = ~clk;

    rr_packet_arbiter #(
        .STALL_TIMEOUT (T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .tail        (tail),
        .DCTS        (dcts),
        .grant       (grant),
        .Xbar_sel    (xbar_sel),
        .RTS         (rts),
        .busy        (busy),
        .err_timeout (err_timeout),
        .rr_ptr      (rr_ptr)
    );

    typedef struct {
        logic [4:0] grant;
        logic [4:0] xbar;
        logic       rts;
        logic       busy;
        logic       err;
        logic [2:0] ptr;
    } exp_t;

    exp_t exp_q[$];
    int   gnt_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: packet owner, priority pointer, stall count, pending error pulse.
    bit m_valid = 0;
    bit m_locked = 0;
    bit m_err = 0;
    int m_owner = 0;
    int m_ptr = 0;
    int m_stall = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, got, want);
        end
    endtask

    task automatic drive(input logic r, input logic [4:0] rq, input logic [4:0] tl,
                         input logic d);
        exp_t e;
        bit   xfer;
        @(posedge clk);
        #1;
        rst  = r;
        req  = rq;
        tail = tl;
        dcts = d;
        if (m_valid) begin
            e.grant = '0;
            e.xbar  = '0;
            e.rts   = 1'b0;
            e.busy  = m_locked;
            e.err   = m_err;
            e.ptr   = 3'(m_ptr);
            if (m_locked) begin
                e.xbar = 5'(1 << m_owner);
                e.rts  = rq[m_owner];
                if (e.rts && d) begin
                    e.grant = e.xbar;
                    gnt_q.push_back(m_owner);
                end
            end
            exp_q.push_back(e);
        end
        xfer = m_valid && m_locked && rq[m_owner] && d;
        if (r) begin
            m_valid  = 1;
            m_locked = 0;
            m_ptr    = 0;
            m_stall  = 0;
            m_err    = 0;
        end else if (m_valid) begin
            m_err = 0;
            if (!m_locked) begin
                for (int k = 0; k < 5; k++) begin
                    if (!m_locked && rq[(m_ptr + k) % 5]) begin
                        m_locked = 1;
                        m_owner  = (m_ptr + k) % 5;
                    end
                end
            end else if (xfer && tl[m_owner]) begin
                m_locked = 0;
                m_ptr    = (m_owner + 1) % 5;
                m_stall  = 0;
            end else if (rq[m_owner]) begin
                m_stall = 0;
            end else if (m_stall == T - 1) begin
                m_locked = 0;
                m_ptr    = (m_owner + 1) % 5;
                m_stall  = 0;
                m_err    = 1;
            end else begin
                m_stall++;
            end
        end
    endtask

    initial begin
        exp_t e;
        int   idx;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("grant", 32'(grant), 32'(e.grant));
                check("xbar_sel", 32'(xbar_sel), 32'(e.xbar));
                check("rts", 32'(rts), 32'(e.rts));
                check("busy", 32'(busy), 32'(e.busy));
                check("err_timeout", 32'(err_timeout), 32'(e.err));
                check("rr_ptr", 32'(rr_ptr), 32'(e.ptr));
            end
            if (grant != '0) begin
                if (gnt_q.size() == 0) begin
                    check("grant_unexpected", 32'(grant), 32'(0));
                end else begin
                    idx = gnt_q.pop_front();
                    check("grant_port", 32'(grant), 32'(1 << idx));
                end
            end
        end
    end

    initial begin
        int         rp;
        int         dp;
        logic [4:0] rq;
        logic [4:0] tl;

        // Reset with everything requesting.
        repeat (2) drive(1'b1, 5'b11111, 5'b00000, 1'b1);
        // Single three-flit packet from N.
        drive(1'b0, 5'b00001, 5'b00000, 1'b1);
        drive(1'b0, 5'b00001, 5'b00000, 1'b1);
        drive(1'b0, 5'b00001, 5'b00000, 1'b1);
        drive(1'b0, 5'b00001, 5'b00001, 1'b1);
        repeat (2) drive(1'b0, 5'b00000, 5'b00000, 1'b1);
        // Full contention, single-flit packets: pointer walks and wraps.
        repeat (14) drive(1'b0, 5'b11111, 5'b11111, 1'b1);
        // Lock: E sends four flits while N requests from the second flit on.
        drive(1'b1, 5'b00000, 5'b00000, 1'b1);
        drive(1'b0, 5'b00010, 5'b00000, 1'b1);
        drive(1'b0, 5'b00010, 5'b00000, 1'b1);
        drive(1'b0, 5'b00011, 5'b00001, 1'b1);
        drive(1'b0, 5'b00011, 5'b00001, 1'b1);
        drive(1'b0, 5'b00011, 5'b00011, 1'b1);
        repeat (4) drive(1'b0, 5'b00001, 5'b00001, 1'b1);
        // Long legal backpressure on W.
        drive(1'b1, 5'b00000, 5'b00000, 1'b1);
        drive(1'b0, 5'b00100, 5'b00000, 1'b1);
        repeat (20) drive(1'b0, 5'b00100, 5'b00100, 1'b0);
        drive(1'b0, 5'b00100, 5'b00100, 1'b1);
        // W drops its request after one flit: stall timeout.
        drive(1'b1, 5'b00000, 5'b00000, 1'b1);
        drive(1'b0, 5'b00100, 5'b00000, 1'b1);
        drive(1'b0, 5'b00100, 5'b00000, 1'b1);
        repeat (7) drive(1'b0, 5'b00000, 5'b00000, 1'b1);
        // Reset in the middle of a packet from S, then all request.
        drive(1'b0, 5'b01000, 5'b00000, 1'b1);
        drive(1'b0, 5'b01000, 5'b00000, 1'b1);
        drive(1'b1, 5'b01000, 5'b00000, 1'b1);
        repeat (4) drive(1'b0, 5'b11111, 5'b00000, 1'b1);

        // Random blocks with varying request and DCTS densities.
        for (int b = 0; b < 60; b++) begin
            case ($urandom_range(2))
                0:       rp = 90;
                1:       rp = 50;
                default: rp = 10;
            endcase
            case ($urandom_range(2))
                0:       dp = 100;
                1:       dp = 60;
                default: dp = 0;
            endcase
            for (int c = 0; c < 50; c++) begin
                for (int i = 0; i < 5; i++) begin
                    rq[i] = ($urandom_range(99) < rp);
                    tl[i] = ($urandom_range(99) < 30);
                end
                drive(($urandom_range(199) == 0), rq, tl, ($urandom_range(99) < dp));
            end
        end

        repeat (3) drive(1'b0, 5'b00000, 5'b00000, 1'b1);
        @(negedge clk);
        #1;
        check("exp_q_drained", 32'(exp_q.size()), 32'(0));
        check("gnt_q_drained", 32'(gnt_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
